// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Drains the pop side of the team's synchronous FIFO and presents the words
// as a valid/ready stream through a 2-entry in-order output buffer. It also
// keeps a running count of the words it has captured.
//
// The FIFO has one cycle of read latency, and its empty flag is registered,
// so it lags the pointer update by one cycle. The reader therefore runs a
// strict IDLE -> REQ -> CAPT sequence. Only one read is ever in flight, and
// empty is looked at only in IDLE, which is when it is up to date.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-low reset
//   enable      1 = permit starting new FIFO reads (an in-flight read completes)
//   fifo_empty  FIFO empty flag (registered, one cycle stale after a read)
//   fifo_data   FIFO data_out, valid the cycle after a read request
//   fifo_rd_en  FIFO read request, one-cycle pulse (high in REQ)
//   m_valid     stream data valid (buffer non-empty)
//   m_ready     downstream accept
//   m_data      oldest buffered word, 0 when the buffer is empty
//   rd_count    words captured from the FIFO, modulo 2^COUNT_WIDTH
//   busy        sequence in progress or buffer non-empty
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_rd_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [COUNT_WIDTH-1:0] rd_count,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  capture;
  logic                  pop;

  assign capture = (state == CAPT);
  assign pop     = m_valid && m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, no matter what order the blocks run in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case statement. A path
  // that left it unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      // Entering REQ only with at most one word buffered leaves a free slot
      // when CAPT completes. Pops during REQ/CAPT can only add more room.
      IDLE: if (enable && !fifo_empty && (occ <= 2'd1)) state_next = REQ;
      REQ:  state_next = CAPT;
      // empty is stale here (pointer moved at the end of REQ), so the
      // decision to read again is deferred to IDLE.
      CAPT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from the state register, so an asynchronous reset
  // drops the request in the same cycle.
  assign fifo_rd_en = (state == REQ);

  // Buffer occupancy. Capture and pop on the same edge cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ <= 2'd0;
    end else begin
      unique case ({capture, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the two data slots are left without reset. m_data is forced to 0
  // whenever occupancy is 0, so their contents are never visible before
  // they have been written.
  always_ff @(posedge clk) begin
    unique case ({capture, pop})
      2'b10: begin
        if (occ == 2'd0) head_q <= fifo_data;
        else             tail_q <= fifo_data;
      end
      2'b01: head_q <= tail_q;
      2'b11: begin
        // Head leaves. The next-oldest word (tail, or the incoming word if
        // the tail is empty) moves up.
        if (occ == 2'd1) begin
          head_q <= fifo_data;
        end else begin
          head_q <= tail_q;
          tail_q <= fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
    end else if (capture) begin
      rd_count <= rd_count + COUNT_WIDTH'(1);
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = m_valid ? head_q : '0;
  assign busy    = (state != IDLE) || (occ != 2'd0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Directed bench for fifo_stream_reader, built with COUNT_WIDTH=4 so that
// the counter wrap is reachable. A behavioural FIFO gives read data one
// cycle after rd_en and updates its empty flag one cycle after the pointer
// moves. Words loaded into the FIFO are also pushed to an expected-word
// queue. A monitor pops that queue on every stream handshake and compares.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] rd_count;
  logic          busy;

  int checks     = 0;
  int errors     = 0;
  int rd_pulses  = 0;
  int over_reads = 0;
  int cyc        = 0;
  int base;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            pulse_cyc[$];

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .rd_count   (rd_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO. empty is computed from the pre-pop size, which gives
  // the one-cycle lag.
  always @(posedge clk) begin
    fifo_empty <= (fifo_q.size() == 0);
    if (fifo_rd_en) begin
      if (fifo_q.size() == 0) over_reads++;
      else                    fifo_data <= fifo_q.pop_front();
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor, sampled mid-cycle. A handshake seen here completes at the
  // following rising edge.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (fifo_rd_en) begin
      rd_pulses++;
      pulse_cyc.push_back(cyc);
    end
    if (reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) check("extra_word", 32'(m_data) | 32'h100, 32'h0);
      else                   check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !busy), 32'h1);
  endtask

  task automatic wait_rd_en(input int budget);
    int n = 0;
    while (!fifo_rd_en && n < budget) begin
      tick();
      n++;
    end
    check("rd_en_seen", 32'(fifo_rd_en), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;

    // Reset held while the FIFO is non-empty.
    push_word(8'hA5);
    repeat (3) begin
      tick();
      check("rst_rd_en",  32'(fifo_rd_en), 32'h0);
      check("rst_valid",  32'(m_valid),    32'h0);
      check("rst_data",   32'(m_data),     32'h0);
      check("rst_count",  32'(rd_count),   32'h0);
      check("rst_busy",   32'(busy),       32'h0);
    end

    // Single word.
    reset = 1'b1;
    tick();
    check("first_rd_en", 32'(fifo_rd_en), 32'h1);
    tick();
    check("rd_en_pulse", 32'(fifo_rd_en), 32'h0);
    tick();
    check("single_valid", 32'(m_valid), 32'h1);
    check("single_data",  32'(m_data),  32'hA5);
    repeat (6) tick();
    check("single_pulses", 32'(rd_pulses), 32'd1);
    check("single_count",  32'(rd_count),  32'd1);
    check("single_idle",   32'(m_valid),   32'h0);

    // Burst at full rate.
    base = rd_pulses;
    pulse_cyc.delete();
    for (int i = 1; i <= 5; i++) push_word(DW'(i));
    wait_idle(60);
    repeat (4) tick();
    check("burst_pulses", 32'(rd_pulses - base), 32'd5);
    check("burst_pulse_q", 32'(pulse_cyc.size()), 32'd5);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check("burst_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd3);
    check("burst_count", 32'(rd_count), 32'd6);

    // Back-pressure: only two reads fit the buffer.
    m_ready = 1'b0;
    base = rd_pulses;
    push_word(8'h10);
    push_word(8'h11);
    push_word(8'h12);
    repeat (20) tick();
    check("bp_pulses", 32'(rd_pulses - base), 32'd2);
    check("bp_valid",  32'(m_valid),  32'h1);
    check("bp_data",   32'(m_data),   32'h10);
    check("bp_count",  32'(rd_count), 32'd8);
    tick();
    check("bp_stable", 32'(m_data), 32'h10);
    m_ready = 1'b1;
    wait_idle(60);
    check("bp_final_count", 32'(rd_count), 32'd9);

    // Counter wrap: 17 words in total.
    for (int i = 0; i < 8; i++) push_word(DW'(8'h20 + i));
    wait_idle(100);
    check("wrap_count", 32'(rd_count), 32'd1);

    // Enable dropped in REQ: that word still arrives, no further read.
    push_word(8'h30);
    push_word(8'h31);
    base = rd_pulses;
    wait_rd_en(20);
    enable = 1'b0;
    repeat (15) tick();
    check("en_pulses",    32'(rd_pulses - base), 32'd1);
    check("en_delivered", 32'(exp_q.size()),     32'd1);
    check("en_count",     32'(rd_count),         32'd2);
    check("en_busy",      32'(busy),             32'h0);
    enable = 1'b1;
    wait_idle(40);
    check("en_resume_count", 32'(rd_count), 32'd3);

    // Reset asserted during REQ.
    push_word(8'h55);
    wait_rd_en(20);
    reset = 1'b0;
    #1;
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'h0);
    check("mid_rst_valid", 32'(m_valid),    32'h0);
    check("mid_rst_data",  32'(m_data),     32'h0);
    check("mid_rst_count", 32'(rd_count),   32'h0);
    check("mid_rst_busy",  32'(busy),       32'h0);
    repeat (2) tick();
    reset = 1'b1;
    wait_idle(30);
    check("post_rst_count", 32'(rd_count),      32'd1);
    check("over_reads",     32'(over_reads),    32'd0);
    check("fifo_drained",   32'(fifo_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Consumer for the team's synchronous FIFO. It drains the FIFO pop port (rd_en / data_out / empty) and presents the words as a valid/ready stream through a 2-entry output buffer.
It tolerates the FIFO's one-cycle read latency and its registered empty flag, which lags pointer updates by one cycle. To do that it never issues a read while empty is stale.
It sits between the FIFO read side and any downstream stream consumer, and keeps a running count of words drained.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data.
COUNT_WIDTH, 16, width of the drained-word counter.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
enable  input  1  1 = permit starting new FIFO reads; 0 = hold off (an in-flight read still completes).
fifo_empty  input  1  FIFO empty flag (registered, lags pointer update by one cycle).
fifo_data  input  DATA_WIDTH  FIFO data_out, valid the cycle after a read request.
fifo_rd_en  output  1  FIFO read request, one-cycle pulse.
m_valid  output  1  stream data valid.
m_ready  input  1  downstream accepts when m_valid && m_ready at a rising edge.
m_data  output  DATA_WIDTH  stream data, oldest buffered word.
rd_count  output  COUNT_WIDTH  number of words captured from FIFO, modulo 2^COUNT_WIDTH.
busy  output  1  1 when state != IDLE or the buffer is non-empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; buffer occupancy=0.
  - fifo_rd_en=0, m_valid=0, m_data=0, rd_count=0, busy=0.
  - fifo_rd_en must drop in the same cycle reset asserts.
  - An abandoned in-flight read is not recovered.
- FSM, 3 states: IDLE, REQ, CAPT.
- fifo_rd_en is combinational: 1 iff state==REQ.
- IDLE -> REQ when enable=1, fifo_empty=0 and occupancy<=1; otherwise stay in IDLE.
- REQ -> CAPT unconditionally. The FIFO samples rd_en at the end of REQ.
- CAPT -> IDLE unconditionally:
  - fifo_data is valid during CAPT and is written to the buffer tail at the end of CAPT.
  - rd_count increments by 1 at the same edge.
  - fifo_empty is stale during CAPT and is ignored.
- Only one read is ever in flight. Peak throughput is 1 word per 3 cycles: rd_en high in cycles n, n+3, n+6, ...
- Buffer: 2-entry in-order FIFO.
  - m_valid = (occupancy != 0); m_data = head entry.
  - m_data is 0 when occupancy==0.
- Pop: m_valid && m_ready at an edge removes the head.
- Capture and pop on the same edge: occupancy unchanged, order preserved. If occupancy was 1, the captured word becomes the head.
- Back-pressure: while m_valid=1 and m_ready=0, m_data and m_valid stay stable.
- Occupancy never exceeds 2. The IDLE entry check guarantees a free slot when CAPT completes.
- enable deasserted during REQ or CAPT: the sequence completes and the word is captured; no new REQ follows.
- rd_count wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- busy = (state != IDLE) || (occupancy != 0).

Test Plan:
- Reset values: hold reset=0 with fifo_empty=0 and enable=1 -> fifo_rd_en=0, m_valid=0, m_data=0, rd_count=0, busy=0 throughout. First fifo_rd_en pulse occurs the cycle after reset releases.
- Single word: FIFO holds 0xA5, m_ready=1 -> fifo_rd_en high exactly one cycle (cycle n); m_valid=1 with m_data=0xA5 in cycle n+2; rd_count=1; no second rd_en after empty settles to 1.
- Burst: FIFO holds 0x01..0x05, m_ready=1 -> rd_en pulses every 3 cycles; stream emits 0x01..0x05 in order; rd_count=5; FIFO never over-read, so no garbage word follows 0x05.
- Back-pressure: FIFO holds 0x10,0x11,0x12 with m_ready=0 -> exactly 2 reads occur, m_data holds 0x10, third rd_en is withheld. Raising m_ready yields 0x10,0x11,0x12 in order.
- Wrap and enable: COUNT_WIDTH=4, drain 17 words -> rd_count=1. Drop enable during a REQ cycle -> that word is still delivered and no further rd_en is issued.
- Reset mid-operation: assert reset during REQ -> fifo_rd_en falls immediately; all outputs return to reset values; after release, normal draining resumes from IDLE.
